// File: rtl/bcd_divisibility_sequencer.sv
// rtl/bcd_divisibility_sequencer.sv - serial 4-digit BCD divisibility-by-3/11 sequencer
//
// Accepts one BCD digit per digit_valid/digit_ready handshake, MSD first,
// keeping running remainders mod 3 and mod 11. After the fourth digit the
// verdict is held behind a result_valid/result_ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   digit_in     BCD digit, most-significant first
//   digit_valid  digit_in is presented
//   digit_ready  block accepts a digit this cycle (COLLECT)
//   result_valid verdict for the completed number is held (REPORT)
//   result_ready consumer takes the verdict
//   div3         number divisible by 3
//   div11        number divisible by 11
//   result       div3 | div11, forced 0 when bcd_error
//   bcd_error    at least one digit of the number was > 9
module bcd_divisibility_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       div3,
  output logic       div11,
  output logic       result,
  output logic       bcd_error
);

  typedef enum logic {
    COLLECT = 1'b0,
    REPORT  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] r3_q, r3_d;
  logic [3:0] r11_q, r11_d;
  logic       err_q, err_d;
  logic       div3_q, div3_d;
  logic       div11_q, div11_d;
  logic       result_q, result_d;
  logic       bcd_error_q, bcd_error_d;

  logic       accept;
  logic [4:0] sum3;
  logic [4:0] red3;
  logic [1:0] r3_next;
  logic [4:0] sum11;
  logic [4:0] red11;
  logic [3:0] r11_next;
  logic       err_next;

  // Remainder arithmetic for the digit currently presented.
  always_comb begin
    // r3 + d is at most 17; peeling 12, 6 and 3 reduces any 0..23 exactly.
    sum3 = {3'b000, r3_q} + {1'b0, digit_in};
    red3 = sum3;
    if (red3 >= 5'd12) red3 = red3 - 5'd12;
    if (red3 >= 5'd6)  red3 = red3 - 5'd6;
    if (red3 >= 5'd3)  red3 = red3 - 5'd3;
    r3_next = red3[1:0];

    // 10 == -1 (mod 11), so appending a digit maps r to (d - r) mod 11.
    // Biasing by 11 keeps the intermediate positive (1..20 for BCD digits).
    sum11 = {1'b0, digit_in} + 5'd11 - {1'b0, r11_q};
    red11 = (sum11 >= 5'd11) ? (sum11 - 5'd11) : sum11;
    r11_next = red11[3:0];

    err_next = err_q | (digit_in > 4'd9);
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r3_d        = r3_q;
    r11_d       = r11_q;
    err_d       = err_q;
    div3_d      = div3_q;
    div11_d     = div11_q;
    result_d    = result_q;
    bcd_error_d = bcd_error_q;
    accept      = 1'b0;

    case (state_q)
      COLLECT: begin
        accept = digit_valid;
        if (accept) begin
          if (cnt_q == 2'd3) begin
            div3_d      = (r3_next == 2'd0);
            div11_d     = (r11_next == 4'd0);
            bcd_error_d = err_next;
            result_d    = ((r3_next == 2'd0) | (r11_next == 4'd0)) & ~err_next;
            // Accumulators restart so the next number begins clean.
            cnt_d       = 2'd0;
            r3_d        = 2'd0;
            r11_d       = 4'd0;
            err_d       = 1'b0;
            state_d     = REPORT;
          end else begin
            cnt_d = cnt_q + 2'd1;
            r3_d  = r3_next;
            r11_d = r11_next;
            err_d = err_next;
          end
        end
      end
      REPORT: begin
        // Digits are not taken here; digit_ready is low so none are lost.
        if (result_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= 2'd0;
      r3_q        <= 2'd0;
      r11_q       <= 4'd0;
      err_q       <= 1'b0;
      div3_q      <= 1'b0;
      div11_q     <= 1'b0;
      result_q    <= 1'b0;
      bcd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r3_q        <= r3_d;
      r11_q       <= r11_d;
      err_q       <= err_d;
      div3_q      <= div3_d;
      div11_q     <= div11_d;
      result_q    <= result_d;
      bcd_error_q <= bcd_error_d;
    end
  end

  assign digit_ready  = (state_q == COLLECT);
  assign result_valid = (state_q == REPORT);
  assign div3         = div3_q;
  assign div11        = div11_q;
  assign result       = result_q;
  assign bcd_error    = bcd_error_q;

endmodule

// File: tb/tb_bcd_divisibility_sequencer.sv
// tb/tb_bcd_divisibility_sequencer.sv - self-checking bench for bcd_divisibility_sequencer
module tb_bcd_divisibility_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       result_valid;
  logic       result_ready;
  logic       div3;
  logic       div11;
  logic       result;
  logic       bcd_error;

  int checks;
  int errors;

  bcd_divisibility_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .digit_ready  (digit_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .div3         (div3),
    .div11        (div11),
    .result       (result),
    .bcd_error    (bcd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Verdict from plain arithmetic on the number value. 10 == 1 mod 3, so the
  // mod-3 verdict stays well defined even with non-BCD digits; div11 is only
  // defined for pure BCD numbers.
  task automatic check_verdict(input string tag, input logic [15:0] digits);
    int  n;
    bit  e3, e11, eerr;
    n    = 0;
    eerr = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] d;
      d = digits[i*4 +: 4];
      n = n * 10 + int'(d);
      if (d > 4'd9) eerr = 1'b1;
    end
    e3  = (n % 3) == 0;
    e11 = (n % 11) == 0;
    chk({tag, ".result_valid"}, {7'd0, result_valid}, 8'd1);
    chk({tag, ".digit_ready"},  {7'd0, digit_ready},  8'd0);
    chk({tag, ".div3"},         {7'd0, div3},         {7'd0, e3});
    if (!eerr) chk({tag, ".div11"}, {7'd0, div11}, {7'd0, e11});
    chk({tag, ".bcd_error"},    {7'd0, bcd_error},    {7'd0, eerr});
    chk({tag, ".result"},       {7'd0, result},       {7'd0, (e3 | e11) & !eerr});
  endtask

  // Sends four digits (optionally with idle gaps), checks the verdict, holds
  // REPORT for 'hold' extra cycles with digit_valid high, then consumes it.
  task automatic run_number(input string tag, input logic [15:0] digits,
                            input int hold, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      if (gaps) begin
        int idle;
        idle = int'($urandom_range(0, 2));
        for (int k = 0; k < idle; k++) begin
          digit_valid = 1'b0;
          digit_in    = 4'($urandom);
          step();
        end
      end
      digit_in    = digits[i*4 +: 4];
      digit_valid = 1'b1;
      chk({tag, ".ready_in"}, {7'd0, digit_ready},  8'd1);
      chk({tag, ".valid_lo"}, {7'd0, result_valid}, 8'd0);
      step();
    end
    // Digits offered during REPORT must be ignored.
    digit_valid  = 1'b1;
    digit_in     = 4'($urandom);
    result_ready = 1'b0;
    check_verdict(tag, digits);
    for (int h = 0; h < hold; h++) begin
      step();
      check_verdict({tag, ".hold"}, digits);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    digit_valid  = 1'b0;
    chk({tag, ".consumed"}, {7'd0, result_valid}, 8'd0);
    chk({tag, ".ready_back"}, {7'd0, digit_ready}, 8'd1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    digit_in     = 4'd0;
    digit_valid  = 1'b0;
    result_ready = 1'b0;

    step();
    chk("reset.digit_ready",  {7'd0, digit_ready},  8'd1);
    chk("reset.result_valid", {7'd0, result_valid}, 8'd0);
    chk("reset.div3",         {7'd0, div3},         8'd0);
    chk("reset.div11",        {7'd0, div11},        8'd0);
    chk("reset.result",       {7'd0, result},       8'd0);
    chk("reset.bcd_error",    {7'd0, bcd_error},    8'd0);
    rst = 1'b0;

    run_number("n0000", 16'h0000, 0, 1'b0);
    run_number("n1234", 16'h1234, 0, 1'b0);
    run_number("n0121", 16'h0121, 0, 1'b0);
    run_number("n9999", 16'h9999, 0, 1'b0);
    run_number("n1A23", 16'h1A23, 0, 1'b0);
    run_number("n0033", 16'h0033, 0, 1'b0);
    run_number("n0003", 16'h0003, 5, 1'b0);

    // Reset after two digits discards the partial number.
    digit_valid = 1'b1;
    digit_in    = 4'd7;
    step();
    step();
    digit_valid = 1'b0;
    rst         = 1'b1;
    #1;
    chk("midrst.digit_ready",  {7'd0, digit_ready},  8'd1);
    chk("midrst.result_valid", {7'd0, result_valid}, 8'd0);
    chk("midrst.div3",         {7'd0, div3},         8'd0);
    chk("midrst.result",       {7'd0, result},       8'd0);
    step();
    rst = 1'b0;
    run_number("n0011", 16'h0011, 0, 1'b0);

    // Reset while a verdict is pending.
    digit_valid = 1'b1;
    digit_in    = 4'd0;
    for (int i = 0; i < 4; i++) step();
    chk("rptrst.pre_valid", {7'd0, result_valid}, 8'd1);
    rst = 1'b1;
    #1;
    chk("rptrst.result_valid", {7'd0, result_valid}, 8'd0);
    chk("rptrst.div11",        {7'd0, div11},        8'd0);
    digit_valid = 1'b0;
    step();
    rst = 1'b0;

    for (int t = 0; t < 30; t++) begin
      logic [15:0] digits;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) digits[i*4 +: 4] = 4'($urandom_range(10, 15));
        else                           digits[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_number($sformatf("rnd%0d", t), digits, int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
